// File: rtl/trap_sequencer_pkg.sv
// Shared trap definitions for the RV32I core: mcause codes, sequencer state
// encoding and the cause-selection helper used by the trap sequencer.
package trap_sequencer_pkg;

  localparam logic [31:0] CAUSE_INST_MISALIGNED = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL_INST    = 32'd2;
  localparam logic [31:0] CAUSE_LOAD_MISALIGNED = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_HANDLER  = 3'd3,
    ST_HALT     = 3'd4
  } trap_state_e;

  typedef enum logic {
    KIND_TRAP   = 1'b0,
    KIND_RETURN = 1'b1
  } redirect_kind_e;

  // Illegal-instruction outranks misaligned; a misaligned request without the
  // memory qualifier is an instruction-fetch misalignment.
  function automatic logic [31:0] trap_cause(input logic illinst,
                                             input logic mem_misaligned);
    if (illinst)
      return CAUSE_ILLEGAL_INST;
    else if (mem_misaligned)
      return CAUSE_LOAD_MISALIGNED;
    else
      return CAUSE_INST_MISALIGNED;
  endfunction

endpackage

// File: rtl/trap_sequencer.sv
// Trap / MRET sequencer: drains the pipeline, writes mcause, hands one redirect
// PC to fetch over valid/ready, and halts the core on a trap inside a handler.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        initiate_illinst,
  input  logic        initiate_misaligned,
  input  logic        mem_misaligned,
  input  logic        mret,
  input  logic [31:0] csr_mepc,
  input  logic        fetch_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        mcause_we,
  output logic [31:0] mcause_wdata,
  output logic        in_handler,
  output logic        halted
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  trap_state_e    state_q, state_d;
  redirect_kind_e kind_q, kind_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    target_q, target_d;
  logic           redirect_valid_q, redirect_valid_d;
  logic [31:0]    redirect_pc_q, redirect_pc_d;
  logic           flush_q, flush_d;
  logic           mcause_we_q, mcause_we_d;
  logic [31:0]    mcause_wdata_q, mcause_wdata_d;
  logic           in_handler_q, in_handler_d;
  logic           halted_q, halted_d;

  logic           trap_req;
  logic [31:0]    mret_target;

  assign trap_req    = initiate_illinst | initiate_misaligned;
  assign mret_target = csr_mepc & 32'hFFFF_FFFC;

  always_comb begin
    state_d          = state_q;
    kind_d           = kind_q;
    cnt_d            = cnt_q;
    target_d         = target_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    mcause_we_d      = 1'b0;
    mcause_wdata_d   = mcause_wdata_q;
    in_handler_d     = in_handler_q;
    halted_d         = halted_q;

    case (state_q)
      ST_IDLE: begin
        if (trap_req) begin
          // Trap wins over a simultaneous MRET: the MRET itself faulted.
          target_d       = TRAP_VECTOR;
          kind_d         = KIND_TRAP;
          mcause_we_d    = 1'b1;
          mcause_wdata_d = trap_cause(initiate_illinst, mem_misaligned);
          flush_d        = 1'b1;
          cnt_d          = FLUSH_INIT;
          state_d        = ST_FLUSH;
        end else if (mret) begin
          target_d = mret_target;
          kind_d   = KIND_RETURN;
          flush_d  = 1'b1;
          cnt_d    = FLUSH_INIT;
          state_d  = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        flush_d = 1'b1;
        if (cnt_q == 4'd0) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target_q;
          state_d          = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_REDIRECT: begin
        flush_d          = 1'b1;
        redirect_valid_d = 1'b1;
        if (fetch_ready) begin
          redirect_valid_d = 1'b0;
          flush_d          = 1'b0;
          if (kind_q == KIND_TRAP) begin
            in_handler_d = 1'b1;
            state_d      = ST_HANDLER;
          end else begin
            in_handler_d = 1'b0;
            state_d      = ST_IDLE;
          end
        end
      end

      ST_HANDLER: begin
        in_handler_d = 1'b1;
        if (trap_req) begin
          mcause_we_d    = 1'b1;
          mcause_wdata_d = trap_cause(initiate_illinst, mem_misaligned);
          halted_d       = 1'b1;
          flush_d        = 1'b1;
          state_d        = ST_HALT;
        end else if (mret) begin
          target_d = mret_target;
          kind_d   = KIND_RETURN;
          flush_d  = 1'b1;
          cnt_d    = FLUSH_INIT;
          state_d  = ST_FLUSH;
        end
      end

      ST_HALT: begin
        flush_d          = 1'b1;
        halted_d         = 1'b1;
        redirect_valid_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q          <= ST_IDLE;
      kind_q           <= KIND_TRAP;
      cnt_q            <= 4'd0;
      target_q         <= 32'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      mcause_we_q      <= 1'b0;
      mcause_wdata_q   <= 32'd0;
      in_handler_q     <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      kind_q           <= kind_d;
      cnt_q            <= cnt_d;
      target_q         <= target_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      mcause_we_q      <= mcause_we_d;
      mcause_wdata_q   <= mcause_wdata_d;
      in_handler_q     <= in_handler_d;
      halted_q         <= halted_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign mcause_we      = mcause_we_q;
  assign mcause_wdata   = mcause_wdata_q;
  assign in_handler     = in_handler_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with default parameters (vector 0, two
// flush cycles); expected values are worked out by hand from the trap timing.
module tb_trap_sequencer;

  logic        clk;
  logic        resetb;
  logic        initiate_illinst;
  logic        initiate_misaligned;
  logic        mem_misaligned;
  logic        mret;
  logic [31:0] csr_mepc;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        mcause_we;
  logic [31:0] mcause_wdata;
  logic        in_handler;
  logic        halted;

  int n_cmp  = 0;
  int n_fail = 0;

  trap_sequencer dut (
    .clk                 (clk),
    .resetb              (resetb),
    .initiate_illinst    (initiate_illinst),
    .initiate_misaligned (initiate_misaligned),
    .mem_misaligned      (mem_misaligned),
    .mret                (mret),
    .csr_mepc            (csr_mepc),
    .fetch_ready         (fetch_ready),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .flush               (flush),
    .mcause_we           (mcause_we),
    .mcause_wdata        (mcause_wdata),
    .in_handler          (in_handler),
    .halted              (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"},   {31'd0, redirect_valid}, 32'd0);
    chk({tag, ".pc"},      redirect_pc,             32'd0);
    chk({tag, ".flush"},   {31'd0, flush},          32'd0);
    chk({tag, ".we"},      {31'd0, mcause_we},      32'd0);
    chk({tag, ".wdata"},   mcause_wdata,            32'd0);
    chk({tag, ".handler"}, {31'd0, in_handler},     32'd0);
    chk({tag, ".halted"},  {31'd0, halted},         32'd0);
  endtask

  initial begin
    resetb              = 1'b0;
    initiate_illinst    = 1'b0;
    initiate_misaligned = 1'b0;
    mem_misaligned      = 1'b0;
    mret                = 1'b0;
    csr_mepc            = 32'd0;
    fetch_ready         = 1'b1;

    tick();
    tick();
    chk_all_zero("reset");
    resetb = 1'b1;
    tick();

    // Illegal-instruction trap, fetch ready throughout
    initiate_illinst = 1'b1;
    tick();
    initiate_illinst = 1'b0;
    $display("txn illegal trap E+1");
    chk("ill.e1.we",    {31'd0, mcause_we},      32'd1);
    chk("ill.e1.wdata", mcause_wdata,            32'd2);
    chk("ill.e1.flush", {31'd0, flush},          32'd1);
    chk("ill.e1.valid", {31'd0, redirect_valid}, 32'd0);
    tick();
    chk("ill.e2.we",    {31'd0, mcause_we},      32'd0);
    chk("ill.e2.flush", {31'd0, flush},          32'd1);
    chk("ill.e2.valid", {31'd0, redirect_valid}, 32'd0);
    tick();
    chk("ill.e3.valid", {31'd0, redirect_valid}, 32'd1);
    chk("ill.e3.pc",    redirect_pc,             32'h0000_0000);
    chk("ill.e3.flush", {31'd0, flush},          32'd1);
    chk("ill.e3.hnd",   {31'd0, in_handler},     32'd0);
    tick();
    chk("ill.e4.hnd",   {31'd0, in_handler},     32'd1);
    chk("ill.e4.flush", {31'd0, flush},          32'd0);
    chk("ill.e4.valid", {31'd0, redirect_valid}, 32'd0);

    // MRET from handler with fetch backpressure
    fetch_ready = 1'b0;
    csr_mepc    = 32'h0000_0106;
    mret        = 1'b1;
    tick();
    mret = 1'b0;
    $display("txn mret with backpressure");
    chk("ret.e1.flush", {31'd0, flush},     32'd1);
    chk("ret.e1.we",    {31'd0, mcause_we}, 32'd0);
    chk("ret.e1.hnd",   {31'd0, in_handler}, 32'd1);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("ret.hold.valid", {31'd0, redirect_valid}, 32'd1);
      chk("ret.hold.pc",    redirect_pc,             32'h0000_0104);
      chk("ret.hold.flush", {31'd0, flush},          32'd1);
      chk("ret.hold.hnd",   {31'd0, in_handler},     32'd1);
      if (i == 5) fetch_ready = 1'b1;
      tick();
    end
    chk("ret.done.valid", {31'd0, redirect_valid}, 32'd0);
    chk("ret.done.hnd",   {31'd0, in_handler},     32'd0);
    chk("ret.done.flush", {31'd0, flush},          32'd0);

    // All requests together: illegal wins, target is the trap vector
    csr_mepc            = 32'h0000_0abc;
    initiate_illinst    = 1'b1;
    initiate_misaligned = 1'b1;
    mret                = 1'b1;
    tick();
    initiate_illinst    = 1'b0;
    initiate_misaligned = 1'b0;
    mret                = 1'b0;
    $display("txn priority all-high");
    chk("pri.we",    {31'd0, mcause_we}, 32'd1);
    chk("pri.wdata", mcause_wdata,       32'd2);
    tick();
    tick();
    chk("pri.valid", {31'd0, redirect_valid}, 32'd1);
    chk("pri.pc",    redirect_pc,             32'h0000_0000);
    tick();
    chk("pri.hnd",   {31'd0, in_handler},     32'd1);

    // Return to IDLE at mepc 0x40
    csr_mepc = 32'h0000_0040;
    mret     = 1'b1;
    tick();
    mret = 1'b0;
    tick();
    tick();
    $display("txn mret to 0x40");
    chk("ret2.pc",  redirect_pc, 32'h0000_0040);
    tick();
    chk("ret2.hnd", {31'd0, in_handler}, 32'd0);

    // Load/store misaligned alone
    initiate_misaligned = 1'b1;
    mem_misaligned      = 1'b1;
    tick();
    initiate_misaligned = 1'b0;
    mem_misaligned      = 1'b0;
    $display("txn load misaligned");
    chk("mis.we",    {31'd0, mcause_we}, 32'd1);
    chk("mis.wdata", mcause_wdata,       32'd4);
    tick();
    tick();
    tick();
    chk("mis.hnd",   {31'd0, in_handler}, 32'd1);

    // Double fault: fetch-misaligned trap inside the handler
    initiate_misaligned = 1'b1;
    tick();
    initiate_misaligned = 1'b0;
    $display("txn double fault");
    chk("df.we",     {31'd0, mcause_we},      32'd1);
    chk("df.wdata",  mcause_wdata,            32'd0);
    chk("df.halted", {31'd0, halted},         32'd1);
    chk("df.flush",  {31'd0, flush},          32'd1);
    mret     = 1'b1;
    csr_mepc = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("df.hold.halted", {31'd0, halted},         32'd1);
      chk("df.hold.flush",  {31'd0, flush},          32'd1);
      chk("df.hold.valid",  {31'd0, redirect_valid}, 32'd0);
      chk("df.hold.we",     {31'd0, mcause_we},      32'd0);
    end
    mret = 1'b0;

    // Reset leaves HALT; then abort a sequence during REDIRECT
    resetb = 1'b0;
    #1;
    chk_all_zero("halt.reset");
    tick();
    resetb      = 1'b1;
    fetch_ready = 1'b0;
    tick();
    initiate_illinst = 1'b1;
    tick();
    initiate_illinst = 1'b0;
    tick();
    tick();
    $display("txn reset abort in redirect");
    chk("abort.pre.valid", {31'd0, redirect_valid}, 32'd1);
    #2;
    resetb = 1'b0;
    #1;
    chk_all_zero("abort");
    tick();
    resetb      = 1'b1;
    fetch_ready = 1'b1;
    tick();
    chk("abort.idle.valid", {31'd0, redirect_valid}, 32'd0);

    // Fresh trap after abort; a repeated request during FLUSH is ignored
    initiate_illinst = 1'b1;
    tick();
    $display("txn trap after abort, request during flush");
    chk("ign.e1.we",    {31'd0, mcause_we}, 32'd1);
    chk("ign.e1.wdata", mcause_wdata,       32'd2);
    initiate_illinst    = 1'b1;
    initiate_misaligned = 1'b1;
    mem_misaligned      = 1'b1;
    tick();
    initiate_illinst    = 1'b0;
    initiate_misaligned = 1'b0;
    mem_misaligned      = 1'b0;
    chk("ign.e2.we",    {31'd0, mcause_we}, 32'd0);
    chk("ign.e2.wdata", mcause_wdata,       32'd2);
    chk("ign.e2.flush", {31'd0, flush},     32'd1);
    tick();
    chk("ign.e3.valid", {31'd0, redirect_valid}, 32'd1);
    chk("ign.e3.we",    {31'd0, mcause_we},      32'd0);
    tick();
    chk("ign.e4.hnd",    {31'd0, in_handler}, 32'd1);
    chk("ign.e4.halted", {31'd0, halted},     32'd0);
    chk("ign.e4.flush",  {31'd0, flush},      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Trap and return sequencer for the embedded RV32I core. It consumes the `initiate_illinst` / `initiate_misaligned` requests raised by the CSR/exception unit and the MRET decode from the XB stage. It drains the pipeline, emits the `mcause` write, and hands a single redirect PC to fetch through a valid/ready handshake. It also detects a trap taken inside a handler (double fault) and halts the core.

## Interface
- `TRAP_VECTOR`, default 32'h0000_0000: handler entry PC; mtvec is direct mode and reads 0.
- `FLUSH_CYCLES`, default 2: cycles `flush` is held before the redirect, covering FD plus XB drain; legal range 1..15.
- `clk` in 1: clock.
- `resetb` in 1: reset, asynchronous, active-low.
- `initiate_illinst` in 1: illegal-instruction or unsupported-category trap request.
- `initiate_misaligned` in 1: misaligned trap request.
- `mem_misaligned` in 1: qualifies `initiate_misaligned`; 1 = load/store address, 0 = instruction fetch.
- `mret` in 1: valid MRET committing in XB.
- `csr_mepc` in 32: current mepc from the CSR file.
- `fetch_ready` in 1: fetch accepts the redirect this cycle.
- `redirect_valid` out 1: redirect request to fetch.
- `redirect_pc` out 32: redirect target.
- `flush` out 1: kill FD/XB contents and force XB_bubble.
- `mcause_we` out 1: one-cycle write strobe to mcause.
- `mcause_wdata` out 32: cause code.
- `in_handler` out 1: core is executing trap handler code.
- `halted` out 1: double fault; core stopped.

## Operation
- FSM states: IDLE, FLUSH, REDIRECT, HANDLER, HALT.
- All outputs are registered. Reset value of every output is 0; state resets to IDLE.
- **IDLE, trap request** (`initiate_illinst` or `initiate_misaligned`):
  - cause = 2 if `initiate_illinst`, else 4 if `mem_misaligned`, else 0.
  - Latch target = `TRAP_VECTOR`, kind = TRAP.
  - Pulse `mcause_we` with `mcause_wdata` = cause.
  - `flush` = 1; counter = `FLUSH_CYCLES`-1; go to FLUSH.
- **IDLE or HANDLER, MRET**:
  - Latch target = {`csr_mepc`[31:2], 2'b00}, kind = RETURN.
  - No mcause write; `flush` = 1; go to FLUSH.
- **Trap and MRET in the same cycle**: the trap wins; the MRET itself faulted.
- `illinst` has priority over `misaligned` when both are asserted.
- **FLUSH**: `flush` = 1. The counter decrements each cycle; when it reaches 0, go to REDIRECT. Requests are ignored because the faulting-path instructions are being killed.
- **REDIRECT**:
  - `flush` = 1, `redirect_valid` = 1, `redirect_pc` = target.
  - `redirect_pc` and `redirect_valid` are held stable until `fetch_ready`.
  - On `fetch_ready`: `redirect_valid` drops next cycle; go to HANDLER if kind = TRAP, or IDLE if kind = RETURN.
  - Requests are ignored while waiting.
- **HANDLER**: `in_handler` = 1.
  - Any trap request goes to HALT: pulse `mcause_we` with the new cause, `halted` = 1.
  - MRET is handled as in IDLE. `in_handler` stays 1 through FLUSH/REDIRECT and clears on return to IDLE.
- **HALT**: `flush` = 1 and `halted` = 1 permanently. `redirect_valid` = 0. Only `resetb` exits.
- **Reset mid-sequence**: asynchronous reset aborts any state immediately; no partial redirect or mcause write survives.

## Timing
- Trap request sampled high at edge E:
  - E+1: `mcause_we` = 1 (single cycle), `flush` = 1.
  - `redirect_valid` first high at E+1+`FLUSH_CYCLES`.
- With `fetch_ready` tied high, `in_handler` rises at E+2+`FLUSH_CYCLES` (E+4 with default parameters).
- MRET has the same latency; `in_handler` falls when IDLE is re-entered.
- `flush` is continuous from E+1 through the cycle in which the redirect is accepted.
- A request asserted for multiple cycles re-triggers only from IDLE or HANDLER.

## Structure
- Shared package (core include, alongside the CSR list) holds:
  - cause constants CAUSE_INST_MISALIGNED = 0, CAUSE_ILLEGAL_INST = 2, CAUSE_LOAD_MISALIGNED = 4;
  - the FSM state encoding.
- Single module; the flush counter is inline (4-bit down-counter). No sub-module.

## Test plan
- **Illegal trap**: `initiate_illinst` pulse with `fetch_ready` = 1 -> `mcause_we` one cycle, `mcause_wdata` = 2, `flush` 3 cycles, `redirect_pc` = 0, `in_handler` = 1 at E+4.
- **Return with backpressure**: MRET in HANDLER with `csr_mepc` = 0x0000_0106, `fetch_ready` held low 5 cycles -> `redirect_pc` = 0x0000_0104 held stable 6 cycles, then IDLE, `in_handler` = 0.
- **Priority**: `initiate_illinst`, `initiate_misaligned` and `mret` all high together -> cause 2, target `TRAP_VECTOR`. `initiate_misaligned` with `mem_misaligned` = 1 alone -> cause 4.
- **Double fault**: trap while in HANDLER -> `halted` = 1, `flush` stuck at 1, no redirect. Further MRET ignored.
- **Reset abort**: `resetb` asserted during REDIRECT -> all outputs 0 asynchronously; a subsequent trap sequences normally.
- **Ignored requests**: trap request during FLUSH -> ignored; exactly one `mcause_we` pulse per sequence.
